// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel divided clock / strobe generator.
// Each channel produces a 50% duty square wave with half-period (H+1)
// system cycles, plus one-cycle rise/fall strobes. Divide ratios are
// reloaded through a per-channel shadow register and take effect at the
// channel's next falling boundary (or at a global sync pulse), so a new
// ratio always starts with a full low phase and never produces a runt.
module clkdiv_multi #(
    parameter int                          CHANNELS  = 2,
    parameter int                          DIV_W     = 16,
    parameter logic [CHANNELS*DIV_W-1:0]   INIT_HALF = {16'd49999, 16'd2},
    parameter int                          CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_half,
    output logic [CHANNELS-1:0] cfg_pend,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act;
        logic [DIV_W-1:0] shd;
        logic             pend;
        logic             out_q;
        logic             rise_q;
        logic             fall_q;
        logic             wr_hit;

        // Out-of-range channel indices never match any channel, so such
        // writes are dropped without any extra range check.
        assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));

        // Per-channel counter, output toggle, strobes and ratio reload.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                act    <= INIT_HALF[i*DIV_W +: DIV_W];
                shd    <= INIT_HALF[i*DIV_W +: DIV_W];
                pend   <= 1'b0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments make every term below read
                // the pre-edge state, so an apply and a config write in the
                // same cycle move the old shadow into act while the shadow
                // takes the new value, and the later pend<=1 wins.
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync) begin
                    cnt   <= '0;
                    out_q <= 1'b0;
                    if (pend) begin
                        act  <= shd;
                        pend <= 1'b0;
                    end
                end else if (en) begin
                    if (cnt >= act) begin
                        cnt    <= '0;
                        out_q  <= ~out_q;
                        rise_q <= ~out_q;
                        fall_q <= out_q;
                        // Apply only at the 1->0 boundary: the new ratio
                        // then begins with a complete low phase.
                        if (out_q && pend) begin
                            act  <= shd;
                            pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                if (wr_hit) begin
                    shd  <= cfg_half;
                    pend <= 1'b1;
                end
            end
        end

        assign clk_out[i]  = out_q;
        assign rise[i]     = rise_q;
        assign fall[i]     = fall_q;
        assign cfg_pend[i] = pend;
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock/strobe generator; successor to the fixed two-output audio divider. Produces CHANNELS independent square-wave outputs plus one-cycle rise/fall strobes from the 100 MHz system clock, with per-channel divide ratios that are reloadable at run time. New ratios take effect glitch-free at period boundaries. A global sync pulse phase-aligns all channels, for example MCLK and LRCK to the codec frame. Sits between the board clock and the codec/serialiser logic in the synthesiser.

## Interface
- CHANNELS, 2: number of output channels (1..16).
- DIV_W, 16: width of each half-period field and counter.
- INIT_HALF, {16'd49999, 16'd2}: packed CHANNELS*DIV_W reset half-period values, channel 0 in the LSBs.
- CH_W, max(1, $clog2(CHANNELS)): width of cfg_ch (derived).

- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global run; low freezes all counters and outputs.
- sync  in  1  one-cycle pulse: restart all channels in phase.
- cfg_wr  in  1  write strobe for the half-period shadow register.
- cfg_ch  in  CH_W  channel index for cfg_wr.
- cfg_half  in  DIV_W  new half-period value H, in cycles minus 1.
- cfg_pend  out  CHANNELS  per-channel flag: shadow written, not yet applied.
- clk_out  out  CHANNELS  divided square outputs.
- rise  out  CHANNELS  one-cycle strobe, high in the first cycle clk_out[i] is 1.
- fall  out  CHANNELS  one-cycle strobe, high in the first cycle clk_out[i] is 0 after a high phase.

## Operation
- Per-channel state: cnt[i], act[i] (active H), shd[i] (shadow H), pend[i], clk_out[i], rise[i], fall[i].
- Reset (rst_n low, async): cnt=0, clk_out=0, rise=0, fall=0, pend=0, act=shd=INIT_HALF slice.
- Priority at each clk edge: sync > en.
- With sync=1:
  - All cnt=0, clk_out=0, rise=0, fall=0.
  - Where pend=1: act<=shd and pend cleared.
  - en is ignored that cycle.
- With sync=0, en=1, per channel:
  - If cnt >= act: cnt<=0 and clk_out toggles.
    - Toggle 0->1: rise=1.
    - Toggle 1->0: fall=1, and if pend then act<=shd and pend<=0. A new ratio therefore starts a full period, low phase first.
  - Otherwise cnt<=cnt+1.
  - rise and fall are 0 in every cycle without a toggle.
- With sync=0, en=0: cnt, act, and clk_out hold. rise=fall=0.
- cfg_wr=1 with cfg_ch<CHANNELS: shd[cfg_ch]<=cfg_half and pend[cfg_ch]<=1.
  - cfg_ch>=CHANNELS: write ignored, no state change.
  - Write while pend=1: shadow overwritten, last write wins.
  - Write in the same cycle as an apply (boundary or sync) on that channel: act takes the old shd, shd takes cfg_half, pend stays 1.
- Arithmetic: unsigned DIV_W compare. Output frequency = f_clk / (2*(H+1)). H=0 gives f_clk/2.
- No combinational path from any input to any output. All outputs are registered.

## Timing
- Half-period = H+1 cycles. Period = 2*(H+1) cycles. Duty is exactly 50%.
- From reset release (en=1, sync=0): clk_out[i] goes to 1 at the (H+1)th rising edge, with rise[i] high for that same cycle.
- After a sync pulse at edge N: all channels sit at cnt=0 from edge N and rise together at edge N+H+1 for equal H.
- Ratio update latency: applied at the next 1->0 toggle of that channel. Worst case is about one period plus one cycle after the write. cfg_pend drops in the same cycle that clk_out falls.
- en deassert/reassert: no lost or extra cycles; the count resumes where it stopped.
- Reset mid-period: outputs go to 0 immediately (async). Pending writes are lost and act returns to INIT.

## Test plan
- Reset defaults: rst_n low, then release with en=1.
  - clk_out[0] period 6 cycles with rise every 6 cycles.
  - clk_out[1] toggles every 50000 cycles.
  - cfg_pend=0 throughout.
- Runtime reload: write ch0 H=4 mid high phase.
  - cfg_pend[0]=1 until the next fall.
  - The following periods are exactly 10 cycles with no short or long pulse.
- Sync alignment: offset channels with different H, pulse sync.
  - Both clk_out=0 next cycle.
  - Rises occur at sync+H0+1 and sync+H1+1.
  - A pending shadow is applied and cfg_pend clears.
- en hold: drop en for 7 cycles mid-count.
  - clk_out is frozen with no strobes.
  - Total cycles to the next toggle = remaining count + 7.
- Config edge cases:
  - Write with cfg_ch=CHANNELS: no effect.
  - Write ch1 in the exact cycle of its falling boundary: the old shadow is applied, the new value stays pending with cfg_pend[1]=1, and it is applied at the next fall.
- Async reset mid-operation: assert rst_n between clk edges.
  - All outputs go to 0 before the next edge.
  - Pending writes are discarded and INIT ratios resume after release.
